// File: rtl/trng_requester.sv
// trng_requester: host-side initiator for a TRNG core.
// Collects 16 entropy words into a 512-bit seed, sequences INIT / RESEED /
// GENERATE operations, and streams each 256-bit result out as 8 words.
// A watchdog in S_WAIT flags a hung core with a sticky Error.
module trng_requester #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_RESEED_INTERVAL = 4,
  parameter int P_TIMEOUT         = 1024
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic                        ent_valid,
  input  logic [P_DATA_WIDTH-1:0]     ent_data,
  output logic                        ent_ready,
  output logic                        TRNG_Go,
  output logic [1:0]                  Op_Type,
  input  logic                        TRNG_Done,
  output logic [16*P_DATA_WIDTH-1:0]  data_in,
  input  logic [8*P_DATA_WIDTH-1:0]   data_out,
  output logic                        rnd_valid,
  output logic [P_DATA_WIDTH-1:0]     rnd_data,
  input  logic                        rnd_ready,
  output logic                        Busy,
  output logic                        Error
);

  localparam int W = P_DATA_WIDTH;
  localparam logic [1:0]  OP_INIT   = 2'h0;
  localparam logic [1:0]  OP_GEN    = 2'h1;
  localparam logic [1:0]  OP_RESEED = 2'h2;
  localparam logic [15:0] WD_LAST   = 16'(P_TIMEOUT - 1);
  localparam logic [7:0]  GEN_LIMIT = 8'(P_RESEED_INTERVAL);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic                   need_init_q, need_init_d;
  logic                   need_seed_q, need_seed_d;
  logic [7:0]             gen_cnt_q, gen_cnt_d;
  logic [3:0]             ent_cnt_q, ent_cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            wd_q, wd_d;
  logic                   err_q, err_d;
  logic [1:0]             op_q, op_d;
  logic [16*W-1:0]        data_in_q, data_in_d;
  // Word 0 of the result (data_out MSBs) lives in buf_q[7].
  logic [7:0][W-1:0]      buf_q, buf_d;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      need_init_q <= 1'b1;
      need_seed_q <= 1'b0;
      gen_cnt_q   <= '0;
      ent_cnt_q   <= '0;
      idx_q       <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      op_q        <= OP_INIT;
      data_in_q   <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      need_init_q <= need_init_d;
      need_seed_q <= need_seed_d;
      gen_cnt_q   <= gen_cnt_d;
      ent_cnt_q   <= ent_cnt_d;
      idx_q       <= idx_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      op_q        <= op_d;
      data_in_q   <= data_in_d;
      buf_q       <= buf_d;
    end
  end

  // Next-state logic: operation sequencing, seed shift-in, result capture.
  always_comb begin
    state_d     = state_q;
    need_init_d = need_init_q;
    need_seed_d = need_seed_q;
    gen_cnt_d   = gen_cnt_q;
    ent_cnt_d   = ent_cnt_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    err_d       = err_q;
    op_d        = op_q;
    data_in_d   = data_in_q;
    buf_d       = buf_q;
    case (state_q)
      S_IDLE: begin
        if (Enable && !err_q) begin
          if (need_init_q || need_seed_q) begin
            state_d = S_COLLECT;
          end else begin
            state_d = S_ISSUE;
            op_d    = OP_GEN;
          end
        end
      end
      S_COLLECT: begin
        if (ent_valid) begin
          data_in_d = {data_in_q[15*W-1:0], ent_data};
          ent_cnt_d = ent_cnt_q + 4'd1;
          if (ent_cnt_q == 4'd15) begin
            state_d = S_ISSUE;
            op_d    = need_init_q ? OP_INIT : OP_RESEED;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        wd_d = wd_q + 16'd1;
        // Done takes priority over a simultaneous watchdog expiry.
        if (TRNG_Done) begin
          if (op_q == OP_GEN) begin
            buf_d     = data_out;
            idx_d     = '0;
            gen_cnt_d = gen_cnt_q + 8'd1;
            if (gen_cnt_q + 8'd1 == GEN_LIMIT) need_seed_d = 1'b1;
            state_d   = S_DRAIN;
          end else begin
            need_init_d = 1'b0;
            need_seed_d = 1'b0;
            gen_cnt_d   = '0;
            state_d     = S_IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          err_d       = 1'b1;
          need_init_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (rnd_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; rnd_data held at zero while not valid.
  always_comb begin
    ent_ready = (state_q == S_COLLECT);
    TRNG_Go   = (state_q == S_ISSUE);
    rnd_valid = (state_q == S_DRAIN);
    Busy      = (state_q != S_IDLE);
    Error     = err_q;
    Op_Type   = op_q;
    data_in   = data_in_q;
    rnd_data  = rnd_valid ? buf_q[3'd7 - idx_q] : '0;
  end

endmodule
